// File: rtl/mem_bus_stage.sv
// MEM pipeline stage: runs loads/stores/LL/SC as a request/acknowledge
// transaction on the external data bus, formats load data, owns the LL/SC
// link bit and asks the control module to stall while a transfer is pending.
module mem_bus_stage #(
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall_i,
   input  logic        flush_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic        whilo_i,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] reg2_i,
   input  logic [31:0] bus_data_i,
   input  logic        bus_ack_i,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_data_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_sel_o,
   output logic        bus_stb_o,
   output logic        stallreq_o,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        whilo_o,
   output logic        llbit_o
);

   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
   localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
   localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;
   localparam int unsigned CW = $clog2(BUS_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_HOLD = 2'd2} state_e;

   // Big-endian byte lanes for the access size.
   function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] a);
      logic [3:0] s;
      case (op)
         EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
            case (a)
               2'b00:   s = 4'b1000;
               2'b01:   s = 4'b0100;
               2'b10:   s = 4'b0010;
               default: s = 4'b0001;
            endcase
         end
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: s = a[1] ? 4'b0011 : 4'b1100;
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

   // Store data replicated across all lanes so the selected lane carries it.
   function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] r);
      logic [31:0] d;
      case (op)
         EXE_SB_OP:            d = {4{r[7:0]}};
         EXE_SH_OP:            d = {2{r[15:0]}};
         EXE_SW_OP, EXE_SC_OP: d = r;
         default:              d = 32'd0;
      endcase
      return d;
   endfunction

   // Value written back on completion: formatted load data, 1 for SC, 0 for stores.
   function automatic logic [31:0] fmt_result(input logic [7:0] op, input logic [1:0] a,
                                              input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (a)
         2'b00:   b = d[31:24];
         2'b01:   b = d[23:16];
         2'b10:   b = d[15:8];
         default: b = d[7:0];
      endcase
      h = a[1] ? d[15:0] : d[31:16];
      case (op)
         EXE_LB_OP:            r = {{24{b[7]}}, b};
         EXE_LBU_OP:           r = {24'd0, b};
         EXE_LH_OP:            r = {{16{h[15]}}, h};
         EXE_LHU_OP:           r = {16'd0, h};
         EXE_LW_OP, EXE_LL_OP: r = d;
         EXE_SC_OP:            r = 32'd1;
         default:              r = 32'd0;
      endcase
      return r;
   endfunction

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          llbit_q, llbit_d;
   logic [31:0]   rd_buf_q, rd_buf_d;
   logic          req_s, stallreq_s;
   logic          is_load_s, is_store_s, is_ll_s, is_sc_s, is_mem_s;
   logic          mem_wreg_s;
   logic [31:0]   result_s;
   logic          unused_stall_s;

   assign unused_stall_s = ^{stall_i[5], stall_i[3:0]};

   assign is_load_s  = (aluop_i == EXE_LB_OP) || (aluop_i == EXE_LBU_OP) ||
                       (aluop_i == EXE_LH_OP) || (aluop_i == EXE_LHU_OP) ||
                       (aluop_i == EXE_LW_OP);
   assign is_store_s = (aluop_i == EXE_SB_OP) || (aluop_i == EXE_SH_OP) ||
                       (aluop_i == EXE_SW_OP);
   assign is_ll_s    = (aluop_i == EXE_LL_OP);
   assign is_sc_s    = (aluop_i == EXE_SC_OP);
   assign is_mem_s   = is_load_s || is_store_s || is_ll_s || is_sc_s;
   assign mem_wreg_s = is_store_s ? 1'b0 : (is_sc_s ? 1'b1 : wreg_i);
   assign result_s   = fmt_result(aluop_i, mem_addr_i[1:0], bus_data_i);

   // State, timeout counter, link bit and read buffer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         llbit_q  <= 1'b0;
         rd_buf_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         llbit_q  <= llbit_d;
         rd_buf_q <= rd_buf_d;
      end
   end

   // Next-state logic and MEM/WB outputs; flush overrides everything.
   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      llbit_d    = llbit_q;
      rd_buf_d   = rd_buf_q;
      req_s      = 1'b0;
      stallreq_s = 1'b0;
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = wdata_i;
      hi_o       = hi_i;
      lo_o       = lo_i;
      whilo_o    = whilo_i;
      if (flush_i) begin
         state_d = S_IDLE;
         llbit_d = 1'b0;
         wreg_o  = 1'b0;
         whilo_o = 1'b0;
         wdata_o = 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (is_mem_s) begin
                  wreg_o  = mem_wreg_s;
                  wdata_o = 32'd0;
                  if (is_sc_s && !llbit_q) begin
                     wdata_o = 32'd0;
                  end else if (!stall_i[4]) begin
                     req_s = 1'b1;
                     if (bus_ack_i) begin
                        wdata_o  = result_s;
                        rd_buf_d = result_s;
                        llbit_d  = is_ll_s ? 1'b1 : (is_sc_s ? 1'b0 : llbit_q);
                     end else begin
                        stallreq_s = 1'b1;
                        state_d    = S_BUSY;
                     end
                  end else begin
                     wdata_o = 32'd0;
                  end
               end else begin
                  wdata_o = wdata_i;
               end
            end
            S_BUSY: begin
               wreg_o = mem_wreg_s;
               if (bus_ack_i) begin
                  req_s    = 1'b1;
                  wdata_o  = result_s;
                  rd_buf_d = result_s;
                  llbit_d  = is_ll_s ? 1'b1 : (is_sc_s ? 1'b0 : llbit_q);
                  state_d  = stall_i[4] ? S_HOLD : S_IDLE;
               end else if (cnt_q == CW'(BUS_TIMEOUT)) begin
                  // Abandoned access: complete with zero data and no write-back.
                  wreg_o   = 1'b0;
                  wdata_o  = 32'd0;
                  rd_buf_d = 32'd0;
                  state_d  = S_IDLE;
               end else begin
                  req_s      = 1'b1;
                  stallreq_s = 1'b1;
                  wdata_o    = 32'd0;
                  cnt_d      = cnt_q + CW'(1);
               end
            end
            S_HOLD: begin
               wreg_o  = mem_wreg_s;
               wdata_o = rd_buf_q;
               if (!stall_i[4]) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_HOLD;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Bus drive; reset kills the request immediately, even mid-transfer.
   always_comb begin
      if (req_s && rst) begin
         bus_stb_o  = 1'b1;
         bus_we_o   = is_store_s || is_sc_s;
         bus_sel_o  = lane_sel(aluop_i, mem_addr_i[1:0]);
         bus_addr_o = {mem_addr_i[31:2], 2'b00};
         bus_data_o = store_data(aluop_i, reg2_i);
      end else begin
         bus_stb_o  = 1'b0;
         bus_we_o   = 1'b0;
         bus_sel_o  = 4'b0000;
         bus_addr_o = 32'd0;
         bus_data_o = 32'd0;
      end
   end

   assign stallreq_o = stallreq_s && rst;
   assign llbit_o    = llbit_q;

endmodule
